// File: rtl/serial_subtractor.sv
// Multi-cycle WIDTH-bit subtractor: diff = a - b - bin, CHUNK bits per clock through one slice.
// Start/busy/done handshake; diff/bout/zero hold their value until the next completion.
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
);

    localparam int NSTEP = WIDTH / CHUNK;
    localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSTEP - 1);

    generate
        if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("serial_subtractor: need 1 <= CHUNK <= WIDTH and WIDTH %% CHUNK == 0");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    cnt_q;
    logic             brw_q;
    logic             busy_q;
    logic             done_q;
    logic             bout_q;
    logic             zero_q;

    logic [CHUNK:0]         slice_d;
    logic [WIDTH+CHUNK-1:0] res_cat;
    logic [WIDTH-1:0]       res_d;
    logic                   accept;

    // The extra MSB of the slice result is the borrow out of this chunk.
    // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
    always_comb begin
        slice_d = {1'b0, a_sh_q[CHUNK-1:0]} - {1'b0, b_sh_q[CHUNK-1:0]} - {{CHUNK{1'b0}}, brw_q};
        res_cat = {slice_d[CHUNK-1:0], res_q};
        res_d   = res_cat[WIDTH+CHUNK-1:CHUNK];
    end

    assign accept = start && (state_q == IDLE || state_q == DONE);

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        brw_q   <= bin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    a_sh_q <= a_sh_q >> CHUNK;
                    b_sh_q <= b_sh_q >> CHUNK;
                    res_q  <= res_d;
                    brw_q  <= slice_d[CHUNK];
                    cnt_q  <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        diff_q  <= res_d;
                        bout_q  <= slice_d[CHUNK];
                        zero_q  <= (res_d == '0);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed vectors on W=8 (C=1, C=4) plus a sweep
// over several WIDTH/CHUNK instances checked against a full-width reference subtraction.
module tb_serial_subtractor;

    localparam int NCFG = 8;
    localparam int CFG_W [NCFG] = '{8, 8, 1, 8, 8, 16, 16, 16};
    localparam int CFG_C [NCFG] = '{1, 4, 1, 2, 8, 1, 2, 16};

    typedef struct {
        int          cfg;
        logic [15:0] diff;
        logic        bout;
        logic        zero;
        longint      acc;
    } exp_t;

    logic            clk;
    logic            rst_n;
    logic [NCFG-1:0] start_v;
    logic [15:0]     a_drv;
    logic [15:0]     b_drv;
    logic            bin_drv;
    logic [NCFG-1:0] busy_v;
    logic [NCFG-1:0] done_v;
    logic [NCFG-1:0] bout_v;
    logic [NCFG-1:0] zero_v;
    logic [15:0]     diff_w [NCFG];

    longint cyc;
    int     errors;
    int     checks;
    exp_t   exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        localparam int W = CFG_W[g];
        localparam int C = CFG_C[g];
        logic [W-1:0] d;
        serial_subtractor #(.WIDTH(W), .CHUNK(C)) u_dut (
            .clk  (clk),
            .rst_n(rst_n),
            .start(start_v[g]),
            .a    (a_drv[W-1:0]),
            .b    (b_drv[W-1:0]),
            .bin  (bin_drv),
            .busy (busy_v[g]),
            .done (done_v[g]),
            .diff (d),
            .bout (bout_v[g]),
            .zero (zero_v[g])
        );
        assign diff_w[g] = 16'(d);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int nstep(input int k);
        return CFG_W[k] / CFG_C[k];
    endfunction

    // Reference: plain full-width subtraction and unsigned compare on masked operands.
    function automatic void model(input int w, input logic [15:0] a, input logic [15:0] b,
                                  input logic bi, output logic [15:0] d, output logic bo);
        logic [16:0] mask;
        logic [16:0] r;
        mask = (17'd1 << w) - 17'd1;
        r    = {1'b0, a} - {1'b0, b} - 17'(bi);
        d    = r[15:0] & mask[15:0];
        bo   = ({1'b0, a} < ({1'b0, b} + 17'(bi)));
    endfunction

    task automatic start_op(input int k, input logic [15:0] a, input logic [15:0] b,
                            input logic bi, input logic [15:0] ed, input logic eb);
        exp_t e;
        a_drv      = a;
        b_drv      = b;
        bin_drv    = bi;
        start_v[k] = 1'b1;
        @(posedge clk);
        #1;
        start_v[k] = 1'b0;
        e.cfg  = k;
        e.diff = ed;
        e.bout = eb;
        e.zero = (ed == 16'h0);
        e.acc  = cyc;
        exp_q.push_back(e);
    endtask

    // Returns at the negedge where done is high; counts busy cycles seen on the way.
    task automatic wait_done(input int k, output int busy_cnt);
        bit seen;
        seen     = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            if (done_v[k]) seen = 1'b1;
            else if (busy_v[k]) busy_cnt++;
        end
        if (!seen) check($sformatf("cfg%0d_done_timeout", k), 32'd0, 32'd1);
        else check($sformatf("cfg%0d_busy_at_done", k), 32'(busy_v[k]), 32'd0);
    endtask

    // Monitor: pops the scoreboard whenever any instance presents done.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int k = 0; k < NCFG; k++) begin
                if (done_v[k]) begin
                    if (exp_q.size() == 0) begin
                        check($sformatf("cfg%0d_unexpected_done", k), 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("cfg%0d_instance", k), 32'(k), 32'(e.cfg));
                        check($sformatf("cfg%0d_diff", k), 32'(diff_w[k]), 32'(e.diff));
                        check($sformatf("cfg%0d_bout", k), 32'(bout_v[k]), 32'(e.bout));
                        check($sformatf("cfg%0d_zero", k), 32'(zero_v[k]), 32'(e.zero));
                        check($sformatf("cfg%0d_latency", k), 32'(cyc - e.acc), 32'(nstep(k)));
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          bc;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [15:0] ed;
        logic [15:0] mask;
        logic        rbi;
        logic        eb;

        errors  = 0;
        checks  = 0;
        rst_n   = 1'b0;
        start_v = '0;
        a_drv   = '0;
        b_drv   = '0;
        bin_drv = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy_v[0]), 32'd0);
        check("rst_done", 32'(done_v[0]), 32'd0);
        check("rst_diff", 32'(diff_w[0]), 32'd0);
        check("rst_bout", 32'(bout_v[0]), 32'd0);
        check("rst_zero", 32'(zero_v[0]), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed W=8, C=1 vectors.
        start_op(0, 16'h05, 16'h03, 1'b0, 16'h02, 1'b0);
        wait_done(0, bc);
        check("busy_cycles_w8c1", 32'(bc), 32'd8);
        start_op(0, 16'h03, 16'h05, 1'b0, 16'hFE, 1'b1);
        wait_done(0, bc);
        start_op(0, 16'h00, 16'h00, 1'b1, 16'hFF, 1'b1);
        wait_done(0, bc);

        // W=8, C=4: two RUN cycles.
        start_op(1, 16'h80, 16'h80, 1'b0, 16'h00, 1'b0);
        wait_done(1, bc);
        check("busy_cycles_w8c4", 32'(bc), 32'd2);

        // A start pulse during RUN must not disturb the in-flight op.
        start_op(0, 16'h10, 16'h01, 1'b0, 16'h0F, 1'b0);
        check("hold_diff_in_run", 32'(diff_w[0]), 32'hFF);
        repeat (2) @(negedge clk);
        a_drv      = 16'hC3;
        b_drv      = 16'h5A;
        bin_drv    = 1'b1;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        check("ignored_start_busy", 32'(busy_v[0]), 32'd1);
        wait_done(0, bc);
        check("busy_cycles_after_pulse", 32'(bc), 32'd6);

        // Start presented in DONE is accepted back-to-back.
        start_op(0, 16'h40, 16'h21, 1'b0, 16'h1F, 1'b0);
        check("b2b_busy", 32'(busy_v[0]), 32'd1);
        check("b2b_done_drop", 32'(done_v[0]), 32'd0);
        wait_done(0, bc);
        @(negedge clk);
        check("idle_busy", 32'(busy_v[0]), 32'd0);
        check("idle_done", 32'(done_v[0]), 32'd0);
        check("idle_hold_diff", 32'(diff_w[0]), 32'h1F);

        // Asynchronous reset at step 3 discards the op.
        start_op(0, 16'h77, 16'h11, 1'b0, 16'h66, 1'b0);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy_v[0]), 32'd0);
        check("midrst_done", 32'(done_v[0]), 32'd0);
        check("midrst_diff", 32'(diff_w[0]), 32'd0);
        check("midrst_bout", 32'(bout_v[0]), 32'd0);
        check("midrst_zero", 32'(zero_v[0]), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        bc = 0;
        repeat (12) begin
            @(negedge clk);
            if (done_v[0]) bc++;
        end
        check("no_done_after_reset", 32'(bc), 32'd0);
        start_op(0, 16'h9A, 16'h3C, 1'b1, 16'h5D, 1'b0);
        wait_done(0, bc);
        @(negedge clk);

        // Sweep every instance against the reference model.
        for (int k = 0; k < NCFG; k++) begin
            mask = 16'((17'd1 << CFG_W[k]) - 17'd1);
            for (int n = 0; n < 150; n++) begin
                ra  = 16'($urandom) & mask;
                rb  = 16'($urandom) & mask;
                rbi = 1'($urandom);
                if (n == 0) rb = ra;
                model(CFG_W[k], ra, rb, rbi, ed, eb);
                start_op(k, ra, rb, rbi, ed, eb);
                wait_done(k, bc);
            end
            @(negedge clk);
        end

        repeat (4) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
